// File: rtl/dqn_state_weight_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dqn_state_weight_scheduler
// Brief    : Serializes DQN state transitions to the main/target nets and
//            arbitrates the shared weight bus between initial load and soft update.
// Revision : 1.0
// ============================================================================
module dqn_state_weight_scheduler #(
   parameter int DATA_WIDTH                    = 32,
   parameter int LAYER_WIDTH                   = 2,
   parameter int WEIGHT_ADDR_WIDTH             = 11,
   parameter int NUMBER_OF_INPUT_NODE          = 4,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
   parameter int NUMBER_OF_OUTPUT_NODE         = 3,
   localparam int STATE_ADDR_WIDTH = (NUMBER_OF_INPUT_NODE > 1) ? $clog2(NUMBER_OF_INPUT_NODE) : 1
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       i_valid,
   output logic                                       o_ready,
   input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_current_state,
   input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_next_state,
   output logic                                       o_main_data_valid,
   output logic [STATE_ADDR_WIDTH-1:0]                o_main_data_addr,
   output logic [DATA_WIDTH-1:0]                      o_main_data,
   output logic                                       o_target_data_valid,
   output logic [STATE_ADDR_WIDTH-1:0]                o_target_data_addr,
   output logic [DATA_WIDTH-1:0]                      o_target_data,
   input  logic                                       i_weight_valid,
   input  logic [LAYER_WIDTH-1:0]                     i_weight_layer,
   input  logic [WEIGHT_ADDR_WIDTH-1:0]               i_weight_addr,
   input  logic [DATA_WIDTH-1:0]                      i_weight,
   input  logic                                       i_soft_req_valid,
   input  logic [LAYER_WIDTH-1:0]                     i_soft_req_layer,
   input  logic [WEIGHT_ADDR_WIDTH-1:0]               i_soft_req_addr,
   input  logic                                       i_soft_wr_valid,
   input  logic [LAYER_WIDTH-1:0]                     i_soft_wr_layer,
   input  logic [WEIGHT_ADDR_WIDTH-1:0]               i_soft_wr_addr,
   input  logic [DATA_WIDTH-1:0]                      i_soft_wr_weight,
   input  logic                                       i_soft_done,
   output logic                                       o_weight_valid,
   output logic                                       o_rw_weight_select,
   output logic [LAYER_WIDTH-1:0]                     o_weight_layer,
   output logic [WEIGHT_ADDR_WIDTH-1:0]               o_weight_addr,
   output logic [DATA_WIDTH-1:0]                      o_weight,
   output logic [1:0]                                 o_mode,
   output logic                                       o_init_done
);

   localparam int LAST_ADDR = NUMBER_OF_OUTPUT_NODE*(NUMBER_OF_HIDDEN_NODE_LAYER_2+1)-1;
   localparam logic [WEIGHT_ADDR_WIDTH-1:0] C_LAST_ADDR = WEIGHT_ADDR_WIDTH'(LAST_ADDR);
   localparam logic [STATE_ADDR_WIDTH-1:0]  C_LAST_K    = STATE_ADDR_WIDTH'(NUMBER_OF_INPUT_NODE-1);

   // ------------------------------------------------------------ serializer
   typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} ser_state_t;

   ser_state_t                                r_ser_state, w_ser_next;
   logic [STATE_ADDR_WIDTH-1:0]               r_k;
   logic [STATE_ADDR_WIDTH-1:0]               w_k_inc;
   logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] r_cur, r_nxt;
   logic                                      r_init_done;
   logic                                      w_handshake, w_last;

   assign o_ready     = (r_ser_state == S_IDLE) && r_init_done;
   assign w_handshake = i_valid && o_ready;
   assign w_last      = (r_k == C_LAST_K);
   assign w_k_inc     = r_k + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ser_state <= S_IDLE;
      else        r_ser_state <= w_ser_next;
   end

   always_comb begin
      w_ser_next = r_ser_state;
      case (r_ser_state)
         S_IDLE:  if (w_handshake) w_ser_next = S_SEND;
         S_SEND:  if (w_last)      w_ser_next = S_IDLE;
         default: w_ser_next = S_IDLE;
      endcase
   end

   // Element 0 is launched from the handshake itself so element k lands k+1 cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k                 <= '0;
         r_cur               <= '0;
         r_nxt               <= '0;
         o_main_data_valid   <= 1'b0;
         o_main_data_addr    <= '0;
         o_main_data         <= '0;
         o_target_data_valid <= 1'b0;
         o_target_data_addr  <= '0;
         o_target_data       <= '0;
      end else begin
         o_main_data_valid   <= 1'b0;
         o_target_data_valid <= 1'b0;
         if (w_handshake) begin
            r_cur               <= i_current_state;
            r_nxt               <= i_next_state;
            r_k                 <= '0;
            o_main_data_valid   <= 1'b1;
            o_main_data_addr    <= '0;
            o_main_data         <= i_current_state[0 +: DATA_WIDTH];
            o_target_data_valid <= 1'b1;
            o_target_data_addr  <= '0;
            o_target_data       <= i_next_state[0 +: DATA_WIDTH];
         end else if (r_ser_state == S_SEND) begin
            if (w_last) begin
               r_k <= '0;
            end else begin
               r_k                 <= w_k_inc;
               o_main_data_valid   <= 1'b1;
               o_main_data_addr    <= w_k_inc;
               o_main_data         <= r_cur[w_k_inc*DATA_WIDTH +: DATA_WIDTH];
               o_target_data_valid <= 1'b1;
               o_target_data_addr  <= w_k_inc;
               o_target_data       <= r_nxt[w_k_inc*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // ------------------------------------------------------------ weight arbiter
   typedef enum logic [1:0] {M_INIT = 2'd0, M_READ = 2'd1, M_WRITE = 2'd2} mode_t;

   mode_t                        r_mode, w_mode_next;
   logic                         w_init_done_next;
   logic                         w_bus_valid, w_bus_sel;
   logic [LAYER_WIDTH-1:0]       w_bus_layer;
   logic [WEIGHT_ADDR_WIDTH-1:0] w_bus_addr;
   logic [DATA_WIDTH-1:0]        w_bus_weight;

   assign o_mode      = r_mode;
   assign o_init_done = r_init_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode             <= M_INIT;
         r_init_done        <= 1'b0;
         o_weight_valid     <= 1'b0;
         o_rw_weight_select <= 1'b0;
         o_weight_layer     <= '0;
         o_weight_addr      <= '0;
         o_weight           <= '0;
      end else begin
         r_mode             <= w_mode_next;
         r_init_done        <= w_init_done_next;
         o_weight_valid     <= w_bus_valid;
         o_rw_weight_select <= w_bus_sel;
         o_weight_layer     <= w_bus_layer;
         o_weight_addr      <= w_bus_addr;
         o_weight           <= w_bus_weight;
      end
   end

   // An initial-load word always wins and drops the arbiter back to INIT.
   always_comb begin
      w_mode_next      = r_mode;
      w_init_done_next = r_init_done;
      w_bus_valid      = 1'b0;
      w_bus_sel        = o_rw_weight_select;
      w_bus_layer      = o_weight_layer;
      w_bus_addr       = o_weight_addr;
      w_bus_weight     = o_weight;
      if (i_weight_valid) begin
         w_bus_valid  = 1'b1;
         w_bus_sel    = 1'b0;
         w_bus_layer  = i_weight_layer;
         w_bus_addr   = i_weight_addr;
         w_bus_weight = i_weight;
         if (r_mode != M_INIT) begin
            w_mode_next = M_INIT;
         end else if ((&i_weight_layer) && (i_weight_addr == C_LAST_ADDR)) begin
            w_mode_next      = M_READ;
            w_init_done_next = 1'b1;
         end
      end else begin
         case (r_mode)
            M_READ: begin
               if (i_soft_req_valid) begin
                  w_bus_valid = 1'b1;
                  w_bus_sel   = 1'b1;
                  w_bus_layer = i_soft_req_layer;
                  w_bus_addr  = i_soft_req_addr;
                  if ((&i_soft_req_layer) && (i_soft_req_addr == C_LAST_ADDR))
                     w_mode_next = M_WRITE;
               end
            end
            M_WRITE: begin
               if (i_soft_wr_valid) begin
                  w_bus_valid  = 1'b1;
                  w_bus_sel    = 1'b0;
                  w_bus_layer  = i_soft_wr_layer;
                  w_bus_addr   = i_soft_wr_addr;
                  w_bus_weight = i_soft_wr_weight;
               end
               if (i_soft_done) w_mode_next = M_READ;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dqn_state_weight_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dqn_state_weight_scheduler
// Brief    : Directed self-checking bench for dqn_state_weight_scheduler.
// Revision : 1.0
// ============================================================================
module tb_dqn_state_weight_scheduler;

   localparam int DW = 32;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_valid;
   logic            o_ready;
   logic [N*DW-1:0] i_current_state, i_next_state;
   logic            o_main_data_valid, o_target_data_valid;
   logic [1:0]      o_main_data_addr, o_target_data_addr;
   logic [DW-1:0]   o_main_data, o_target_data;
   logic            i_weight_valid;
   logic [1:0]      i_weight_layer;
   logic [10:0]     i_weight_addr;
   logic [DW-1:0]   i_weight;
   logic            i_soft_req_valid;
   logic [1:0]      i_soft_req_layer;
   logic [10:0]     i_soft_req_addr;
   logic            i_soft_wr_valid;
   logic [1:0]      i_soft_wr_layer;
   logic [10:0]     i_soft_wr_addr;
   logic [DW-1:0]   i_soft_wr_weight;
   logic            i_soft_done;
   logic            o_weight_valid, o_rw_weight_select;
   logic [1:0]      o_weight_layer;
   logic [10:0]     o_weight_addr;
   logic [DW-1:0]   o_weight;
   logic [1:0]      o_mode;
   logic            o_init_done;

   int total = 0;
   int bad   = 0;

   dqn_state_weight_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_current_state(i_current_state), .i_next_state(i_next_state),
      .o_main_data_valid(o_main_data_valid), .o_main_data_addr(o_main_data_addr),
      .o_main_data(o_main_data),
      .o_target_data_valid(o_target_data_valid), .o_target_data_addr(o_target_data_addr),
      .o_target_data(o_target_data),
      .i_weight_valid(i_weight_valid), .i_weight_layer(i_weight_layer),
      .i_weight_addr(i_weight_addr), .i_weight(i_weight),
      .i_soft_req_valid(i_soft_req_valid), .i_soft_req_layer(i_soft_req_layer),
      .i_soft_req_addr(i_soft_req_addr),
      .i_soft_wr_valid(i_soft_wr_valid), .i_soft_wr_layer(i_soft_wr_layer),
      .i_soft_wr_addr(i_soft_wr_addr), .i_soft_wr_weight(i_soft_wr_weight),
      .i_soft_done(i_soft_done),
      .o_weight_valid(o_weight_valid), .o_rw_weight_select(o_rw_weight_select),
      .o_weight_layer(o_weight_layer), .o_weight_addr(o_weight_addr), .o_weight(o_weight),
      .o_mode(o_mode), .o_init_done(o_init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [1:0] layer, input logic [10:0] addr, input logic [DW-1:0] w);
      i_weight_valid = 1'b1; i_weight_layer = layer; i_weight_addr = addr; i_weight = w;
      tick();
      i_weight_valid = 1'b0;
      check("ld_valid", o_weight_valid, 1);
      check("ld_sel", o_rw_weight_select, 0);
      check("ld_addr", o_weight_addr, addr);
      check("ld_data", o_weight, w);
   endtask

   // Handshake one transition, then scramble the inputs to prove they were captured.
   task automatic send_check(input logic [N*DW-1:0] cur, input logic [N*DW-1:0] nxt);
      i_current_state = cur; i_next_state = nxt; i_valid = 1'b1;
      check("ready_idle", o_ready, 1);
      tick();
      i_valid = 1'b0; i_current_state = '1; i_next_state = '1;
      for (int k = 0; k < N; k++) begin
         check("main_valid", o_main_data_valid, 1);
         check("tgt_valid", o_target_data_valid, 1);
         check("main_addr", o_main_data_addr, k);
         check("tgt_addr", o_target_data_addr, k);
         check("main_data", o_main_data, cur[k*DW +: DW]);
         check("tgt_data", o_target_data, nxt[k*DW +: DW]);
         check("ready_busy", o_ready, 0);
         tick();
      end
      check("main_valid_end", o_main_data_valid, 0);
      check("tgt_valid_end", o_target_data_valid, 0);
      check("addr_hold", o_main_data_addr, N-1);
      check("data_hold", o_main_data, cur[(N-1)*DW +: DW]);
      check("ready_again", o_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; i_valid = 1'b0;
      i_current_state = '0; i_next_state = '0;
      i_weight_valid = 1'b0; i_weight_layer = '0; i_weight_addr = '0; i_weight = '0;
      i_soft_req_valid = 1'b0; i_soft_req_layer = '0; i_soft_req_addr = '0;
      i_soft_wr_valid = 1'b0; i_soft_wr_layer = '0; i_soft_wr_addr = '0; i_soft_wr_weight = '0;
      i_soft_done = 1'b0;
      tick(); tick();
      check("rst_ready", o_ready, 0);
      check("rst_mode", o_mode, 0);
      check("rst_init_done", o_init_done, 0);
      check("rst_wvalid", o_weight_valid, 0);
      check("rst_mvalid", o_main_data_valid, 0);
      check("rst_waddr", o_weight_addr, 0);
      rst_n = 1'b1;

      // transition offered before init is refused
      i_current_state = {32'd4, 32'd3, 32'd2, 32'd1};
      i_valid = 1'b1;
      tick();
      check("preinit_ready", o_ready, 0);
      tick();
      check("preinit_mvalid", o_main_data_valid, 0);
      i_valid = 1'b0;

      // initial load; layer 3 at a non-final address must not finish init
      load_word(2'd1, 11'd0, 32'h1000);
      load_word(2'd2, 11'd5, 32'h2005);
      load_word(2'd3, 11'd5, 32'h3005);
      check("init_mode_mid", o_mode, 0);
      check("init_done_mid", o_init_done, 0);
      load_word(2'd3, 11'd98, 32'h0000ABCD);
      check("init_layer", o_weight_layer, 3);
      check("init_mode", o_mode, 1);
      check("init_done", o_init_done, 1);
      tick();
      check("init_idle_wvalid", o_weight_valid, 0);

      send_check({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});

      // READ: soft_done and writes ignored, requests mirrored with weight held
      i_soft_done = 1'b1; i_soft_wr_valid = 1'b1;
      tick();
      i_soft_done = 1'b0; i_soft_wr_valid = 1'b0;
      check("read_ign_mode", o_mode, 1);
      check("read_ign_wvalid", o_weight_valid, 0);
      for (int a = 0; a <= 98; a++) begin
         i_soft_req_valid = 1'b1; i_soft_req_layer = 2'd3; i_soft_req_addr = 11'(a);
         tick();
         check("req_valid", o_weight_valid, 1);
         check("req_sel", o_rw_weight_select, 1);
         check("req_addr", o_weight_addr, a);
         if (a == 0) check("req_weight_held", o_weight, 32'h0000ABCD);
         if (a == 97) check("req_mode_mid", o_mode, 1);
      end
      i_soft_req_valid = 1'b0;
      check("write_mode", o_mode, 2);

      // WRITE: stray requests ignored, write-backs forwarded
      i_soft_req_valid = 1'b1; i_soft_req_addr = 11'd3;
      i_soft_wr_valid = 1'b1; i_soft_wr_layer = 2'd2; i_soft_wr_addr = 11'd7; i_soft_wr_weight = 32'h55;
      tick();
      i_soft_req_valid = 1'b0; i_soft_wr_valid = 1'b0;
      check("wr_valid", o_weight_valid, 1);
      check("wr_sel", o_rw_weight_select, 0);
      check("wr_layer", o_weight_layer, 2);
      check("wr_addr", o_weight_addr, 7);
      check("wr_data", o_weight, 32'h55);
      i_soft_done = 1'b1;
      tick();
      i_soft_done = 1'b0;
      check("done_mode", o_mode, 1);

      // back to WRITE, then an initial-load word collides with a write-back
      i_soft_req_valid = 1'b1; i_soft_req_layer = 2'd3; i_soft_req_addr = 11'd98;
      tick();
      i_soft_req_valid = 1'b0;
      check("write_mode2", o_mode, 2);
      i_weight_valid = 1'b1; i_weight_layer = 2'd1; i_weight_addr = 11'd4; i_weight = 32'h77;
      i_soft_wr_valid = 1'b1; i_soft_wr_layer = 2'd2; i_soft_wr_addr = 11'd9; i_soft_wr_weight = 32'h99;
      tick();
      i_weight_valid = 1'b0; i_soft_wr_valid = 1'b0;
      check("prio_data", o_weight, 32'h77);
      check("prio_addr", o_weight_addr, 4);
      check("prio_layer", o_weight_layer, 1);
      check("prio_sel", o_rw_weight_select, 0);
      check("prio_mode", o_mode, 0);
      check("prio_init_done", o_init_done, 1);
      check("prio_ready", o_ready, 1);

      // soft traffic in INIT is ignored
      i_soft_req_valid = 1'b1; i_soft_wr_valid = 1'b1; i_soft_done = 1'b1;
      tick();
      i_soft_req_valid = 1'b0; i_soft_wr_valid = 1'b0; i_soft_done = 1'b0;
      check("init_ign_wvalid", o_weight_valid, 0);
      check("init_ign_mode", o_mode, 0);
      load_word(2'd3, 11'd98, 32'h1234);
      check("reinit_mode", o_mode, 1);

      // transfer with concurrent weight traffic, then reset at element 2
      send_check({32'hD, 32'hC, 32'hB, 32'hA}, {32'h1D, 32'h1C, 32'h1B, 32'h1A});
      i_current_state = {32'd40, 32'd30, 32'd20, 32'd10};
      i_next_state    = {32'd80, 32'd70, 32'd60, 32'd50};
      i_valid = 1'b1;
      i_soft_req_valid = 1'b1; i_soft_req_layer = 2'd0; i_soft_req_addr = 11'd1;
      tick();
      i_valid = 1'b0;
      tick();
      i_soft_req_valid = 1'b0;
      tick();
      check("pre_rst_addr", o_main_data_addr, 2);
      check("pre_rst_data", o_main_data, 32'd30);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mvalid", o_main_data_valid, 0);
      check("rst_mid_mdata", o_main_data, 0);
      check("rst_mid_tdata", o_target_data, 0);
      check("rst_mid_init", o_init_done, 0);
      check("rst_mid_waddr", o_weight_addr, 0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("post_rst_mvalid", o_main_data_valid, 0);
         check("post_rst_ready", o_ready, 0);
      end
      check("post_rst_mode", o_mode, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dqn_state_weight_scheduler.md
DQN_STATE_WEIGHT_SCHEDULER -- requirements
Module: dqn_state_weight_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of states and weights.
REQ-002 SHALL have parameter LAYER_WIDTH, default 2, weight layer select width.
REQ-003 SHALL have parameter WEIGHT_ADDR_WIDTH, default 11, weight address width.
REQ-004 SHALL have parameter NUMBER_OF_INPUT_NODE, default 4, state vector length N (N >= 1).
REQ-005 SHALL have parameters NUMBER_OF_HIDDEN_NODE_LAYER_2 (default 32) and NUMBER_OF_OUTPUT_NODE (default 3); LAST_ADDR = NUMBER_OF_OUTPUT_NODE*(NUMBER_OF_HIDDEN_NODE_LAYER_2+1)-1.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have the state ports: i_valid  input  1  transition offered; o_ready  output  1  transition accepted when high with i_valid; i_current_state  input  N*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH]; i_next_state  input  N*DATA_WIDTH  same packing.
REQ-008 SHALL have the main-net data outputs o_main_data_valid (1), o_main_data_addr (clog2(N), min 1), o_main_data (DATA_WIDTH), and the same three outputs with the o_target_ prefix.
REQ-009 SHALL have the initial-load inputs i_weight_valid (1), i_weight_layer (LAYER_WIDTH), i_weight_addr (WEIGHT_ADDR_WIDTH), i_weight (DATA_WIDTH).
REQ-010 SHALL have the soft-update inputs i_soft_req_valid/i_soft_req_layer/i_soft_req_addr (read request), i_soft_wr_valid/i_soft_wr_layer/i_soft_wr_addr/i_soft_wr_weight (write-back), and i_soft_done (1).
REQ-011 SHALL have the weight-bus outputs o_weight_valid (1), o_rw_weight_select (1, 0 = write, 1 = read), o_weight_layer, o_weight_addr and o_weight, broadcast to both nets.
REQ-012 SHALL have the outputs o_mode (2; 0 = INIT, 1 = READ, 2 = WRITE) and o_init_done (1).

Function
REQ-013 State serializer has two states, IDLE and SEND, plus a counter k.
REQ-014 o_ready = 1 only in IDLE with o_init_done = 1.
REQ-015 On a handshake the serializer captures both vectors, enters SEND, sets k = 0, and the transition does not change during SEND.
REQ-016 In SEND, each cycle the serializer drives both net data ports with valid = 1, addr = k, main data = current[k] and target data = next[k]; element k is registered and appears k+1 cycles after the handshake cycle.
REQ-017 After k = N-1 the serializer returns to IDLE; the next handshake is possible in the cycle after the last element (throughput is one transition per N+1 cycles).
REQ-018 Data valid outputs are 0 in every cycle that does not send an element; addr/data hold their last values.
REQ-019 Weight arbiter FSM has states INIT, READ and WRITE, and all bus outputs are registered with 1-cycle latency.
REQ-020 In INIT the arbiter forwards i_weight_* with select = 0; i_weight_valid with layer = all-ones and addr = LAST_ADDR moves it to READ and sets o_init_done = 1 (sticky).
REQ-021 In READ the arbiter forwards i_soft_req_* with select = 1 and o_weight unchanged; a request with layer = all-ones and addr = LAST_ADDR moves it to WRITE.
REQ-022 In WRITE the arbiter forwards i_soft_wr_* with select = 0; i_soft_done moves it to READ.
REQ-023 i_weight_valid in READ or WRITE has priority: it is forwarded as a write that cycle, the FSM enters INIT, o_init_done stays 1, and the soft inputs are ignored that cycle.
REQ-024 Soft inputs are ignored in INIT, and i_soft_done is ignored outside WRITE.
REQ-025 The serializer and the arbiter run independently; a transfer in progress is not paused by any weight activity.

Reset
REQ-026 While rst_n = 0 the block SHALL drive all valid outputs to 0, o_ready to 0, o_init_done to 0, o_mode to 0 (INIT), the serializer to IDLE with k = 0, and all data/addr/layer/select outputs to 0.
REQ-027 Reset asserted mid-SEND or mid-WRITE SHALL abandon the operation with no further valid pulse after deassertion.

Verification
REQ-028 Reset, then i_valid = 1 before init -> o_ready = 0, no data valid.
REQ-029 Load layers 1..3, last being layer 3 addr 98 -> 1 cycle later o_weight_valid = 1 and select = 0; o_mode = 1 and o_init_done = 1.
REQ-030 After init, N = 4, current = {4,3,2,1}, next = {8,7,6,5} -> cycles +1..+4: addr 0..3, main 1..4, target 5..8; o_ready low during +1..+4.
REQ-031 READ with requests for layer 3 addr 0..98 -> mirrored with select = 1, then o_mode = 2; writes forwarded with select = 0; i_soft_done -> o_mode = 1.
REQ-032 i_weight_valid and i_soft_wr_valid in the same cycle in WRITE -> only i_weight is forwarded, o_mode = 0, and o_ready stays 1.
REQ-033 rst_n pulsed at SEND element 2 -> all outputs 0, no element 3, and o_ready = 0 until init repeats.
